// File: rtl/encoder_83_sync.sv
`default_nettype none
// ============================================================================
// Module      : encoder_83_sync
// Description : Registered 8-to-3 priority encoder for board switch/button
//               lines. Raw inputs are passed through a 2-FF synchroniser and a
//               debouncer, then encoded (bit 7 highest priority). Presents a
//               valid flag, a one-cycle change strobe and a press counter.
//               Optional macro ENCODER_83_ONEHOT_CHECK_EN flags multi-hot
//               debounced vectors on err and suppresses the code meanwhile;
//               when undefined, err stays 0.
// Revision    : 1.0 - initial release
// ============================================================================
module encoder_83_sync #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] din,
  output logic [2:0] dout,
  output logic       valid,
  output logic       stb,
  output logic       err,
  output logic [7:0] evt_cnt
);

  // Counter must hold values 0..DEBOUNCE_CYCLES inclusive.
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] c_DEB    = CW'(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] c_DEB_M1 = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  logic [7:0]    r_s1;
  logic [7:0]    r_din_s;
  logic [7:0]    r_samp;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_stab;
  state_t        r_state;
  logic [2:0]    r_dout;
  logic          r_valid;
  logic          r_stb;
  logic          r_err;
  logic [7:0]    r_evt_cnt;

  logic [2:0]    w_code;
  logic          w_multi_hot;

  // Two-flop synchroniser for the asynchronous input lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1    <= 8'd0;
      r_din_s <= 8'd0;
    end else begin
      r_s1    <= din;
      r_din_s <= r_s1;
    end
  end

  // Debounce: accept a vector only after it has been stable long enough.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_samp <= 8'd0;
      r_cnt  <= '0;
      r_stab <= 8'd0;
    end else begin
      if (r_din_s != r_samp) begin
        r_samp <= r_din_s;
        r_cnt  <= '0;
      end else if (r_cnt < c_DEB) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if ((r_cnt == c_DEB_M1) && (r_din_s == r_samp)) begin
        r_stab <= r_samp;
      end
    end
  end

  // Priority encode: later (higher) indices override lower ones.
  always_comb begin
    w_code = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (r_stab[i]) w_code = 3'(i);
    end
  end

`ifdef ENCODER_83_ONEHOT_CHECK_EN
  // More than one bit set when clearing the lowest set bit leaves anything.
  assign w_multi_hot = |(r_stab & (r_stab - 8'd1));
`else
  assign w_multi_hot = 1'b0;
`endif

  // Output FSM: tracks presence of a code and strobes on each new code.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_dout    <= 3'd0;
      r_valid   <= 1'b0;
      r_stb     <= 1'b0;
      r_err     <= 1'b0;
      r_evt_cnt <= 8'd0;
    end else begin
      r_stb <= 1'b0;
      r_err <= w_multi_hot;
      if (w_multi_hot) begin
        // Ambiguous input: withdraw the code but keep dout as it was.
        r_state <= IDLE;
        r_valid <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            r_valid <= 1'b0;
            if (r_stab != 8'd0) begin
              r_state   <= ACTIVE;
              r_valid   <= 1'b1;
              r_dout    <= w_code;
              r_stb     <= 1'b1;
              r_evt_cnt <= r_evt_cnt + 8'd1;
            end
          end
          ACTIVE: begin
            r_valid <= 1'b1;
            if (r_stab == 8'd0) begin
              r_state <= IDLE;
              r_valid <= 1'b0;
            end else if (w_code != r_dout) begin
              r_dout <= w_code;
              r_stb  <= 1'b1;
            end
          end
          default: begin
            r_state <= IDLE;
            r_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign dout    = r_dout;
  assign valid   = r_valid;
  assign stb     = r_stb;
  assign err     = r_err;
  assign evt_cnt = r_evt_cnt;

endmodule
`default_nettype wire

// File: tb/tb_encoder_83_sync.sv
`default_nettype none
// ============================================================================
// Module      : tb_encoder_83_sync
// Description : Directed self-checking bench for encoder_83_sync with
//               DEBOUNCE_CYCLES=4 (input change to output takes 8 edges).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_encoder_83_sync;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = 8'h00;
  logic [2:0] dout;
  logic       valid;
  logic       stb;
  logic       err;
  logic [7:0] evt_cnt;

  int n_checks = 0;
  int n_fail   = 0;
  int bad;
  logic [7:0] exp_evt;

  encoder_83_sync #(.DEBOUNCE_CYCLES(4)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .din     (din),
    .dout    (dout),
    .valid   (valid),
    .stb     (stb),
    .err     (err),
    .evt_cnt (evt_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    tick(2);
    chk("rst_dout", 32'(dout), 0);
    chk("rst_valid", 32'(valid), 0);
    chk("rst_stb", 32'(stb), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_evt", 32'(evt_cnt), 0);
    rst = 1'b0;

    // Idle input for 20 clocks: nothing must appear
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1);
      if (stb !== 1'b0 || valid !== 1'b0) bad++;
    end
    chk("idle_quiet", 32'(bad), 0);
    chk("idle_dout", 32'(dout), 0);
    chk("idle_evt", 32'(evt_cnt), 0);

    // First press: 8'h08 appears exactly 8 edges later
    din = 8'h08;
    tick(7);
    chk("p1_valid_early", 32'(valid), 0);
    tick(1);
    chk("p1_valid", 32'(valid), 1);
    chk("p1_dout", 32'(dout), 3);
    chk("p1_stb", 32'(stb), 1);
    chk("p1_evt", 32'(evt_cnt), 1);
    tick(1);
    chk("p1_stb_once", 32'(stb), 0);
    exp_evt = 8'd1;

    // Short 2-clock dropouts must be filtered out
    bad = 0;
    for (int k = 0; k < 3; k++) begin
      din = 8'h00;
      for (int i = 0; i < 2; i++) begin
        tick(1);
        if (stb !== 1'b0 || valid !== 1'b1 || dout !== 3'd3) bad++;
      end
      din = 8'h08;
      for (int i = 0; i < 10; i++) begin
        tick(1);
        if (stb !== 1'b0 || valid !== 1'b1 || dout !== 3'd3) bad++;
      end
    end
    chk("bounce_filtered", 32'(bad), 0);
    chk("bounce_evt", 32'(evt_cnt), 1);

    // Add bit 7 while bit 3 is held
    din = 8'h88;
`ifdef ENCODER_83_ONEHOT_CHECK_EN
    tick(8);
    chk("mh_err", 32'(err), 1);
    chk("mh_valid", 32'(valid), 0);
    chk("mh_stb", 32'(stb), 0);
    chk("mh_dout_hold", 32'(dout), 3);
    chk("mh_evt", 32'(evt_cnt), 1);
    din = 8'h80;
    tick(8);
    chk("oh_err", 32'(err), 0);
    chk("oh_valid", 32'(valid), 1);
    chk("oh_dout", 32'(dout), 7);
    chk("oh_stb", 32'(stb), 1);
    chk("oh_evt", 32'(evt_cnt), 2);
    exp_evt = 8'd2;
`else
    tick(7);
    chk("pri_dout_early", 32'(dout), 3);
    tick(1);
    chk("pri_dout", 32'(dout), 7);
    chk("pri_stb", 32'(stb), 1);
    chk("pri_valid", 32'(valid), 1);
    chk("pri_err", 32'(err), 0);
    chk("pri_evt", 32'(evt_cnt), 1);
`endif
    tick(1);
    chk("chg_stb_once", 32'(stb), 0);
    chk("chg_evt_keep", 32'(evt_cnt), 32'(exp_evt));

    // Release: valid drops, no strobe
    din = 8'h00;
    tick(8);
    chk("rel_valid", 32'(valid), 0);
    chk("rel_stb", 32'(stb), 0);
    chk("rel_dout_hold", 32'(dout), 7);

    // Restart counter from zero, then 256 press/release cycles of bit 0
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("rst2_evt", 32'(evt_cnt), 0);
    bad = 0;
    for (int k = 0; k < 256; k++) begin
      din = 8'h01;
      tick(8);
      if (valid !== 1'b1 || dout !== 3'd0 || stb !== 1'b1) bad++;
      din = 8'h00;
      tick(8);
      if (valid !== 1'b0) bad++;
    end
    chk("wrap_press_ok", 32'(bad), 0);
    chk("wrap_evt", 32'(evt_cnt), 0);

    // Mid-operation asynchronous reset
    din = 8'h40;
    tick(8);
    chk("pre_rst_valid", 32'(valid), 1);
    chk("pre_rst_dout", 32'(dout), 6);
    chk("pre_rst_evt", 32'(evt_cnt), 1);
    rst = 1'b1;
    #1;
    chk("async_valid", 32'(valid), 0);
    chk("async_dout", 32'(dout), 0);
    chk("async_evt", 32'(evt_cnt), 0);
    tick(1);
    rst = 1'b0;
    tick(7);
    chk("post_rst_early", 32'(valid), 0);
    tick(1);
    chk("post_rst_valid", 32'(valid), 1);
    chk("post_rst_dout", 32'(dout), 6);
    chk("post_rst_stb", 32'(stb), 1);
    chk("post_rst_evt", 32'(evt_cnt), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
